// File: rtl/approx_mult_pkg.sv
// Shared widths and the approximate/exact column boundary for the approximate multiplier.
package approx_mult_pkg;
    localparam int OPW         = 8;
    localparam int PRODW       = 16;
    localparam int APPROX_COLS = 7;

    typedef logic [OPW-1:0]   opnd_t;
    typedef logic [PRODW-1:0] prod_t;
endpackage

// File: rtl/approx_mult_nov_core.sv
// Combinational approximate 8x8 multiplier core: OR-reduced low columns and
// an exact carry-save reduction of the high columns.
module approx_mult_nov_core
    import approx_mult_pkg::*;
(
    input  logic [OPW-1:0]   num1,
    input  logic [OPW-1:0]   num2,
    output logic [PRODW-1:0] p
);
    logic [OPW-1:0][PRODW-1:0] w_row;
    logic [OPW-1:0][PRODW-1:0] w_s;
    logic [OPW-1:0][PRODW-1:0] w_c;
    logic [APPROX_COLS-1:0]    w_lo;
    logic [PRODW-1:0]          w_hi;

    genvar gi, gw;

    // Each row keeps only the pp bits whose weight lands in the exact region.
    for (gi = 0; gi < OPW; gi++) begin : g_row
        localparam logic [OPW-1:0] HMASK =
            (gi >= APPROX_COLS) ? {OPW{1'b1}} : OPW'(8'hFF << (APPROX_COLS - gi));
        assign w_row[gi] = PRODW'(num1 & {OPW{num2[gi]}} & HMASK) << gi;
    end

    for (gw = 0; gw < APPROX_COLS; gw++) begin : g_lo
        logic [gw:0] w_colpp;
        for (gi = 0; gi <= gw; gi++) begin : g_pp
            assign w_colpp[gi] = num1[gw-gi] & num2[gi];
        end
        assign w_lo[gw] = |w_colpp;
    end

    // Carry-save array: fold one row per stage, then a single final adder.
    assign w_s[0] = w_row[0];
    assign w_c[0] = '0;
    for (gi = 1; gi < OPW; gi++) begin : g_csa
        assign w_s[gi] = w_s[gi-1] ^ w_c[gi-1] ^ w_row[gi];
        assign w_c[gi] = ((w_s[gi-1] & w_c[gi-1]) | (w_s[gi-1] & w_row[gi]) |
                          (w_c[gi-1] & w_row[gi])) << 1;
    end

    assign w_hi = w_s[OPW-1] + w_c[OPW-1];
    assign p    = {w_hi[PRODW-1:APPROX_COLS], w_lo};
endmodule

// File: rtl/approx_mult_nov.sv
// Approximate 8x8 unsigned multiplier with one registered output stage.
module approx_mult_nov
    import approx_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [OPW-1:0]   num1,
    input  logic [OPW-1:0]   num2,
    output logic             out_valid,
    output logic [PRODW-1:0] prod
);
    logic [PRODW-1:0] w_p;
    logic [PRODW-1:0] r_prod;
    logic             r_vld;

    approx_mult_nov_core u_core (
        .num1 (num1),
        .num2 (num2),
        .p    (w_p)
    );

    // Product only updates on accepted pairs; it holds across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) r_prod <= w_p;
        end
    end

    assign prod      = r_prod;
    assign out_valid = r_vld;
endmodule

// File: tb/tb_approx_mult_nov.sv
// Self-checking bench for approx_mult_nov: directed, reset, gating, sweep and random checks.
module tb_approx_mult_nov;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  num1, num2;
    logic        out_valid;
    logic [15:0] prod;

    int total = 0;
    int bad   = 0;
    int exp_prod;
    int bitdiff [16];

    approx_mult_nov dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .prod      (prod)
    );

    always #5 clk = ~clk;

    // Reference: exact weight sum for columns >= 7, plain OR for columns below.
    function automatic int ref_p(input int a, input int b);
        int h = 0;
        int l = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (((a >> j) & 1) == 1 && ((b >> i) & 1) == 1) begin
                    if (i + j >= 7) h = h + (1 << (i + j));
                    else            l = l | (1 << (i + j));
                end
        return h | l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int a, input int b, input bit v);
        @(negedge clk);
        num1     = a[7:0];
        num2     = b[7:0];
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input int a, input int b);
        step(a, b, 1'b1);
        exp_prod = ref_p(a, b);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(prod), 32'(exp_prod));
    endtask

    initial begin
        int a, b, ex;
        rst_n = 1'b0; in_valid = 1'b0; num1 = '0; num2 = '0;
        foreach (bitdiff[k]) bitdiff[k] = 0;
        #12;
        chk("reset_prod", 32'(prod), 32'd0);
        chk("reset_vld", 32'(out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed values against spec-stated results.
        step(1, 1, 1);     chk("d_1x1", 32'(prod), 32'd1);
        step(3, 3, 1);     chk("d_3x3", 32'(prod), 32'd7);
        step(15, 15, 1);   chk("d_15x15", 32'(prod), 32'd127);
        step(16, 16, 1);   chk("d_16x16", 32'(prod), 32'd256);
        step(128, 1, 1);   chk("d_128x1", 32'(prod), 32'd128);
        step(0, 200, 1);   chk("d_0x200", 32'(prod), 32'd0);
        step(255, 255, 1); chk("d_255x255", 32'(prod), 32'd64383);
        chk("d_vld", 32'(out_valid), 32'd1);

        // Valid gating: idle cycle holds prod and drops out_valid.
        step_chk("g_first", 200, 77);
        step(9, 9, 1'b0);
        chk("g_idle_vld", 32'(out_valid), 32'd0);
        chk("g_idle_hold", 32'(prod), 32'(ref_p(200, 77)));
        step_chk("g_second", 13, 211);

        // Asynchronous reset mid-stream.
        @(negedge clk); num1 = 8'd99; num2 = 8'd123; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_prod", 32'(prod), 32'd0);
        chk("rst_async_vld", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_vld", 32'(out_valid), 32'd0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_rel_vld", 32'(out_valid), 32'd0);
        chk("rst_rel_prod", 32'(prod), 32'd0);
        step_chk("rst_first", 99, 123);

        // Exhaustive triangular sweep, back-to-back.
        for (int x = 1; x < 256; x++) begin
            for (int y = 1; y <= x; y++) begin
                step(x, y, 1'b1);
                ex = x * y;
                chk("sweep", 32'(prod), 32'(ref_p(x, y)));
                total++;
                assert (int'(prod) <= ex) else begin
                    bad++;
                    $error("FAIL sweep_le observed=%0d expected<=%0d", prod, ex);
                end
                for (int k = 0; k < 16; k++)
                    if (prod[k] != ex[k]) bitdiff[k]++;
            end
        end
        $display("per-bit diffs vs exact (bit15..0): %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d",
                 bitdiff[15], bitdiff[14], bitdiff[13], bitdiff[12], bitdiff[11], bitdiff[10],
                 bitdiff[9], bitdiff[8], bitdiff[7], bitdiff[6], bitdiff[5], bitdiff[4],
                 bitdiff[3], bitdiff[2], bitdiff[1], bitdiff[0]);

        // Power-of-two operands are exact.
        for (int s = 0; s < 8; s++) begin
            a = int'($urandom_range(255, 0));
            step(a, 1 << s, 1'b1);
            chk("pow2_exact", 32'(prod), 32'(a * (1 << s)));
        end

        // Commutativity with random pairs, both orders against the model.
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(255, 0));
            step(a, b, 1'b1);
            chk("comm_ab", 32'(prod), 32'(ref_p(a, b)));
            step(b, a, 1'b1);
            chk("comm_ba", 32'(prod), 32'(ref_p(a, b)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
